// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract that reuses one 5-bit ripple-carry adder, one slice per clock, LSB first.
// Optional signed-overflow output Ovf is compiled in when SEQ_OVF_EN is defined.

module mws_fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module mws_rca5 (
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic       Cin,
  output logic [4:0] S,
  output logic       Cout
);
  logic [5:0] w_c;

  assign w_c[0] = Cin;
  assign Cout   = w_c[5];

  mws_fa u_fa [4:0] (
    .A    (A),
    .B    (B),
    .Cin  (w_c[4:0]),
    .S    (S),
    .Cout (w_c[5:1])
  );
endmodule

module multiword_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Start,
  input  logic                  Sub,
  input  logic [5*NWORDS-1:0]   A,
  input  logic [5*NWORDS-1:0]   B,
  output logic                  Busy,
  output logic                  Done,
  output logic [5*NWORDS-1:0]   S,
`ifdef SEQ_OVF_EN
  output logic                  Ovf,
`endif
  output logic                  Cout
);
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 r_state, w_next;
  logic [NWORDS-1:0][4:0] r_opa, r_opb, r_work, w_final;
  logic [KW-1:0]          r_k;
  logic                   r_sub, r_carry, r_cout;
  logic [5*NWORDS-1:0]    r_s;
  logic [4:0]             w_a, w_b, w_s;
  logic                   w_co, w_last, w_start;

  assign w_a     = r_opa[r_k];
  assign w_b     = r_opb[r_k] ^ {5{r_sub}};
  assign w_last  = (r_k == KW'(NWORDS-1));
  assign w_start = Start && (r_state != RUN);

  mws_rca5 u_add (
    .A    (w_a),
    .B    (w_b),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_co)
  );

  // Final result merges the slice being produced this cycle with the stored lower slices.
  always_comb begin
    w_final      = r_work;
    w_final[r_k] = w_s;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = Start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_work  <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_start) begin
      r_opa   <= A;
      r_opb   <= B;
      r_sub   <= Sub;
      r_carry <= Sub;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_work[r_k] <= w_s;
      r_carry     <= w_co;
      if (w_last) begin
        r_s    <= w_final;
        r_cout <= w_co;
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

`ifdef SEQ_OVF_EN
  logic r_ovf;
  // w_b already carries the Sub inversion, so its MSB is the effective B sign.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      r_ovf <= 1'b0;
    else if (!w_start && r_state == RUN && w_last)
      r_ovf <= (w_a[4] == w_b[4]) && (w_s[4] != w_a[4]);
  end
  assign Ovf = r_ovf;
`endif

  assign Busy = (r_state == RUN);
  assign Done = (r_state == DONE);
  assign S    = r_s;
  assign Cout = r_cout;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer: vector table plus start-in-run, back-to-back and mid-run reset.
module tb_multiword_add_sequencer;
  localparam int NW = 4;
  localparam int W  = 5*NW;

  logic         CLK = 1'b0, RSTn = 1'b0, Start = 1'b0, Sub = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Busy, Done, Cout;
  logic [W-1:0] S;
`ifdef SEQ_OVF_EN
  logic         Ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  multiword_add_sequencer #(.NWORDS(NW)) dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .Start (Start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .S     (S),
`ifdef SEQ_OVF_EN
    .Ovf   (Ovf),
`endif
    .Cout  (Cout)
  );

  typedef struct {
    logic         sub;
    logic [W-1:0] a, b, s;
    logic         cout, ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive Start for one edge, then scramble inputs so only latched copies can matter.
  task automatic issue(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    Start = 1'b1; Sub = sub; A = a; B = b;
    @(negedge CLK);
    Start = 1'b0; Sub = ~sub; A = W'($urandom); B = W'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int busy_cnt;
    busy_cnt = 0;
    issue(v.sub, v.a, v.b);
    repeat (NW) begin
      if (Busy && !Done) busy_cnt++;
      @(negedge CLK);
    end
    chk({tag, "/busy_cycles"}, W'(busy_cnt), W'(NW));
    chk({tag, "/done"},  W'(Done), W'(1));
    chk({tag, "/busy_at_done"}, W'(Busy), W'(0));
    chk({tag, "/S"},    S, v.s);
    chk({tag, "/Cout"}, W'(Cout), W'(v.cout));
`ifdef SEQ_OVF_EN
    chk({tag, "/Ovf"},  W'(Ovf), W'(v.ovf));
`endif
    @(negedge CLK);
    chk({tag, "/done_fall"}, W'(Done), W'(0));
  endtask

  initial begin
    int cnt;
    vecs[0] = '{1'b0, 20'h00001, 20'hFFFFF, 20'h00000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 20'h0001F, 20'h00001, 20'h00020, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 20'h07FFF, 20'h00001, 20'h08000, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 20'h12345, 20'h02345, 20'h10000, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 20'h00000, 20'h00001, 20'hFFFFF, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 20'h7FFFF, 20'h00001, 20'h80000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 20'h80000, 20'h00001, 20'h7FFFF, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 20'h00002, 20'h00003, 20'h00005, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 20'hABCDE, 20'h54321, 20'hFFFFF, 1'b0, 1'b0};

    repeat (2) @(negedge CLK);
    chk("rst/S", S, '0);
    chk("rst/Cout", W'(Cout), W'(0));
    chk("rst/Busy", W'(Busy), W'(0));
    chk("rst/Done", W'(Done), W'(0));
    RSTn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Result holds after completion.
    repeat (3) @(negedge CLK);
    chk("hold/S", S, 20'hFFFFF);

    // Start pulsed mid-run must be ignored.
    issue(1'b0, 20'h00010, 20'h00020);
    Start = 1'b1; A = 20'hFFFFF; B = 20'hFFFFF;
    @(negedge CLK);
    Start = 1'b0;
    repeat (NW-1) @(negedge CLK);
    chk("ign/done", W'(Done), W'(1));
    chk("ign/S", S, 20'h00030);
    @(negedge CLK);
    chk("ign/idle_busy", W'(Busy), W'(0));
    chk("ign/idle_done", W'(Done), W'(0));

    // Back-to-back: Start held in the DONE cycle.
    issue(1'b0, 20'h00005, 20'h00006);
    repeat (NW) @(negedge CLK);
    chk("b2b/done1", W'(Done), W'(1));
    chk("b2b/S1", S, 20'h0000B);
    Start = 1'b1; Sub = 1'b1; A = 20'h00010; B = 20'h00001;
    @(negedge CLK);
    Start = 1'b0; Sub = 1'b0;
    cnt = 1;
    chk("b2b/no_idle", W'(Busy), W'(1));
    while (!Done && cnt < 20) begin
      @(negedge CLK);
      cnt++;
    end
    chk("b2b/spacing", W'(cnt), W'(NW+1));
    chk("b2b/S2", S, 20'h0000F);
    chk("b2b/Cout2", W'(Cout), W'(1));

    // Asynchronous reset in the second RUN cycle.
    issue(1'b0, 20'h00001, 20'h00001);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("arst/S", S, '0);
    chk("arst/Cout", W'(Cout), W'(0));
    chk("arst/Busy", W'(Busy), W'(0));
    chk("arst/Done", W'(Done), W'(0));
    @(negedge CLK);
    RSTn = 1'b1;
    run_vec('{1'b0, 20'h00003, 20'h00004, 20'h00007, 1'b0, 1'b0}, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
